seq_multiplier: RTL and testbench

Sequential unsigned shift-add multiplier, the inverse of the team's shift-subtract divider. It exposes the same `run`/`ready` handshake as the divider controller, so the same test harness and top-level sequencer can drive it. The block contains its own control FSM, iteration counter and product/multiplicand datapath, and produces one `2*WIDTH`-bit product per operation after `WIDTH` add/shift iterations.

---
 rtl/mult_pkg.sv | 17 +
 rtl/seq_mult_ctrl.sv | 80 ++++++++
 rtl/seq_multiplier.sv | 61 ++++++
 tb/tb_seq_multiplier.sv | 147 ++++++++++++++
 4 files changed

// File: rtl/mult_pkg.sv
// Shared types and constants for the shift-add multiplier.
package mult_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_DONE = 2'd2
    } mult_state_e;

    localparam int MULT_WIDTH_DEFAULT = 32;

    // Counter must reach WIDTH itself, hence WIDTH+1 codes.
    function automatic int mult_cnt_w(input int width);
        return $clog2(width + 1);
    endfunction

endpackage

// File: rtl/seq_mult_ctrl.sv
// Control FSM, iteration counter and registered ready/busy flags.
import mult_pkg::*;

module seq_mult_ctrl #(
    parameter int WIDTH = MULT_WIDTH_DEFAULT
) (
    input  logic clk,
    input  logic reset,
    input  logic run,
    output logic load,
    output logic iter,
    output logic ready,
    output logic busy
);

    localparam int CW = mult_cnt_w(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    mult_state_e   state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          ready_q, ready_d;
    logic          busy_q, busy_d;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        ready_d = ready_q;
        busy_d  = busy_q;
        load    = 1'b0;
        iter    = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (run) begin
                    load    = 1'b1;
                    cnt_d   = '0;
                    busy_d  = 1'b1;
                    state_d = ST_CALC;
                end
            end
            ST_CALC: begin
                iter  = 1'b1;
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == LAST) begin
                    busy_d  = 1'b0;
                    ready_d = 1'b1;
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                if (!run) begin
                    ready_d = 1'b0;
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
                ready_d = 1'b0;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            ready_q <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ready_q <= ready_d;
            busy_q  <= busy_d;
        end
    end

    assign ready = ready_q;
    assign busy  = busy_q;

endmodule

// File: rtl/seq_multiplier.sv
// Unsigned shift-add multiplier: WIDTH add/shift iterations per product.
import mult_pkg::*;

module seq_multiplier #(
    parameter int WIDTH = MULT_WIDTH_DEFAULT
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               run,
    input  logic [WIDTH-1:0]   multiplicand,
    input  logic [WIDTH-1:0]   multiplier,
    output logic [2*WIDTH-1:0] product,
    output logic               ready,
    output logic               busy
);

    logic load;
    logic iter;

    seq_mult_ctrl #(.WIDTH(WIDTH)) u_ctrl (
        .clk   (clk),
        .reset (reset),
        .run   (run),
        .load  (load),
        .iter  (iter),
        .ready (ready),
        .busy  (busy)
    );

    logic [2*WIDTH-1:0] prod_q, prod_d;
    logic [WIDTH-1:0]   mcand_q, mcand_d;
    logic [WIDTH:0]     sum;
    logic [WIDTH:0]     acc;

    // Carry out of the upper-half add becomes the new MSB after the shift.
    always_comb begin
        sum     = {1'b0, prod_q[2*WIDTH-1:WIDTH]} + {1'b0, mcand_q};
        acc     = prod_q[0] ? sum : {1'b0, prod_q[2*WIDTH-1:WIDTH]};
        prod_d  = prod_q;
        mcand_d = mcand_q;
        if (load) begin
            prod_d  = {{WIDTH{1'b0}}, multiplier};
            mcand_d = multiplicand;
        end else if (iter) begin
            prod_d = {acc, prod_q[WIDTH-1:1]};
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            prod_q  <= '0;
            mcand_q <= '0;
        end else begin
            prod_q  <= prod_d;
            mcand_q <= mcand_d;
        end
    end

    assign product = prod_q;

endmodule

// File: tb/tb_seq_multiplier.sv
// Scoreboard bench for seq_multiplier at the default width.
module tb_seq_multiplier;

    localparam int W = 32;

    logic           clk;
    logic           reset;
    logic           run;
    logic [W-1:0]   mcand;
    logic [W-1:0]   mplier;
    logic [2*W-1:0] product;
    logic           ready;
    logic           busy;

    int n_cmp;
    int n_bad;
    logic [2*W-1:0] exp_q[$];
    logic [2*W-1:0] last_p;

    seq_multiplier #(.WIDTH(W)) dut (
        .clk          (clk),
        .reset        (reset),
        .run          (run),
        .multiplicand (mcand),
        .multiplier   (mplier),
        .product      (product),
        .ready        (ready),
        .busy         (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: run did not finish");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // drop_at/chg_at: iteration index at which run drops / operands change
    task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b,
                         input int drop_at, input int chg_at);
        logic [2*W-1:0] e;
        @(negedge clk);
        run    = 1'b1;
        mcand  = a;
        mplier = b;
        exp_q.push_back({{W{1'b0}}, a} * {{W{1'b0}}, b});
        @(posedge clk);
        #1;
        chk("busy_e0", 64'(busy), 64'd1);
        chk("ready_e0", 64'(ready), 64'd0);
        for (int i = 1; i <= W; i++) begin
            @(negedge clk);
            if (i == chg_at) begin
                mcand  = $urandom;
                mplier = $urandom;
            end
            if (i == drop_at) run = 1'b0;
            @(posedge clk);
            #1;
            if (i < W) begin
                if (busy !== 1'b1 || ready !== 1'b0) begin
                    chk("busy_mid", {62'd0, busy, ready}, 64'd2);
                end
            end else begin
                chk("busy_end", 64'(busy), 64'd0);
                chk("ready_end", 64'(ready), 64'd1);
                e = exp_q.pop_front();
                chk("product", product, e);
                last_p = e;
            end
        end
        if (run) begin
            @(posedge clk);
            #1;
            chk("ready_hold", 64'(ready), 64'd1);
            chk("prod_hold", product, last_p);
            @(negedge clk);
            run = 1'b0;
        end
        @(posedge clk);
        #1;
        chk("ready_clr", 64'(ready), 64'd0);
        chk("prod_idle", product, last_p);
    endtask

    initial begin
        n_cmp  = 0;
        n_bad  = 0;
        reset  = 1'b0;
        run    = 1'b0;
        mcand  = '0;
        mplier = '0;
        last_p = '0;
        #12;
        chk("rst_prod", product, 64'd0);
        chk("rst_ready", 64'(ready), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        @(negedge clk);
        reset = 1'b1;

        do_op(32'd3, 32'd5, 0, 0);
        do_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 0);
        do_op(32'h1234_5678, 32'd0, 0, 0);
        do_op(32'd0, 32'h8000_0001, 0, 0);
        do_op(32'hDEAD_BEEF, 32'h0BAD_CAFE, 10, 5);

        // Abort mid-operation with an asynchronous reset pulse.
        @(negedge clk);
        run    = 1'b1;
        mcand  = 32'h55;
        mplier = 32'hAA;
        for (int i = 0; i <= 16; i++) @(posedge clk);
        #2;
        run   = 1'b0;
        reset = 1'b0;
        #1;
        chk("arst_prod", product, 64'd0);
        chk("arst_ready", 64'(ready), 64'd0);
        chk("arst_busy", 64'(busy), 64'd0);
        @(negedge clk);
        reset  = 1'b1;
        last_p = '0;
        do_op(32'd7, 32'd6, 0, 0);

        do_op(32'd2, 32'd9, 0, 0);
        do_op(32'd100, 32'd100, 0, 0);
        for (int k = 0; k < 3; k++) begin
            do_op($urandom, $urandom, 0, 0);
        end

        chk("sb_empty", 64'(exp_q.size()), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
